ex_stage: RTL and testbench

- Execute stage of the 5-stage RV32I(+MUL) pipeline.
- Consumes the ID/EX register fields and the forwardA/forwardB selects from the forwarding unit.
- Selects operands, runs the ALU or an iterative 32-cycle multiplier, and resolves branches and jumps.
- Owns the EX/MEM pipeline register and feeds ex_mem_rd, ex_mem_RegWrite and ex_mem_alu_result back to the forwarding path.

---
 rtl/ex_stage_pkg.sv | 38 +++
 rtl/ex_stage_if.sv | 52 +++++
 rtl/ex_stage_iter_mul.sv | 94 +++++++++
 rtl/ex_stage.sv | 181 ++++++++++++++++++
 tb/tb_ex_stage.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_pkg.sv
// ex_pkg: shared encodings for the execute stage.
//   - ALU operation codes carried on id_ex_alu_op
//   - forwarding select codes carried on forwardA / forwardB
//   - branch funct3 codes carried on id_ex_br_type
//   - iterative multiplier state encoding
package ex_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;
  localparam logic [3:0] ALU_MUL   = 4'd11;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX pipeline register fields into the execute stage and
// the EX/MEM pipeline register fields out of it.
//   master: upstream/consumer side (drives id_ex_*, reads ex_mem_*)
//   slave : the execute stage (reads id_ex_*, drives ex_mem_*)
interface ex_stage_if #(
  parameter int XLEN = 32
);
  import ex_pkg::*;

  logic            id_ex_valid;
  logic [XLEN-1:0] id_ex_pc;
  logic [XLEN-1:0] id_ex_rs1_data;
  logic [XLEN-1:0] id_ex_rs2_data;
  logic [XLEN-1:0] id_ex_imm;
  logic [4:0]      id_ex_rd;
  logic [3:0]      id_ex_alu_op;
  logic            id_ex_alu_src;
  logic            id_ex_RegWrite;
  logic            id_ex_MemRead;
  logic            id_ex_MemWrite;
  logic            id_ex_branch;
  logic [2:0]      id_ex_br_type;
  logic            id_ex_jal;
  logic            id_ex_jalr;

  logic            ex_mem_valid;
  logic            ex_mem_RegWrite;
  logic            ex_mem_MemRead;
  logic            ex_mem_MemWrite;
  logic [4:0]      ex_mem_rd;
  logic [XLEN-1:0] ex_mem_alu_result;
  logic [XLEN-1:0] ex_mem_store_data;

  modport master (
    output id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
           id_ex_rd, id_ex_alu_op, id_ex_alu_src, id_ex_RegWrite,
           id_ex_MemRead, id_ex_MemWrite, id_ex_branch, id_ex_br_type,
           id_ex_jal, id_ex_jalr,
    input  ex_mem_valid, ex_mem_RegWrite, ex_mem_MemRead, ex_mem_MemWrite,
           ex_mem_rd, ex_mem_alu_result, ex_mem_store_data
  );

  modport slave (
    input  id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
           id_ex_rd, id_ex_alu_op, id_ex_alu_src, id_ex_RegWrite,
           id_ex_MemRead, id_ex_MemWrite, id_ex_branch, id_ex_br_type,
           id_ex_jal, id_ex_jalr,
    output ex_mem_valid, ex_mem_RegWrite, ex_mem_MemRead, ex_mem_MemWrite,
           ex_mem_rd, ex_mem_alu_result, ex_mem_store_data
  );

endinterface

// File: rtl/ex_stage_iter_mul.sv
// iter_mul: shift-add multiplier producing the low XLEN bits of op_a*op_b,
// one multiplier bit per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request in IDLE; operands are captured on that edge
//   hold       : keeps the FSM in DONE until the result can be consumed
//   op_a, op_b : operands (sampled only at start)
//   busy       : high in BUSY and combinationally in the start cycle
//   done       : high in DONE, product valid
//   product    : low XLEN bits of the product
module iter_mul
  import ex_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            hold,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  mul_state_e      state_q, state_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MUL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MUL_IDLE: if (start) state_d = MUL_BUSY;
      MUL_BUSY: if (cnt_q == CNT_LAST) state_d = MUL_DONE;
      MUL_DONE: if (!hold) state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == MUL_BUSY) || ((state_q == MUL_IDLE) && start);
    done    = (state_q == MUL_DONE);
    product = acc_q;
  end

  // Operands are captured at start because the forwarding sources that
  // produced them drain away while the front of the pipe is frozen.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if ((state_q == MUL_IDLE) && start) begin
      mcand_d  = op_a;
      mplier_d = op_b;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (state_q == MUL_BUSY) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the RV32I(+MUL) pipeline.
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : ID/EX fields in, EX/MEM register out
//   forwardA/forwardB : operand source select (00 rf, 10 EX/MEM, 01 MEM/WB)
//   mem_wb_fwd_data   : writeback value for forward code 01
//   mem_stall         : downstream hold, freezes the EX/MEM register
//   ex_busy           : multiplier active, front of pipe must hold
//   branch_taken      : redirect fetch and flush IF/ID, ID/EX
//   branch_target     : redirect address
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  ex_stage_if.slave       bus,
  input  logic [1:0]      forwardA,
  input  logic [1:0]      forwardB,
  input  logic [XLEN-1:0] mem_wb_fwd_data,
  input  logic            mem_stall,
  output logic            ex_busy,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target
);

  logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_result, link_addr, jalr_sum;
  logic [4:0]      shamt;
  logic            br_cond, mul_start, mul_busy, mul_done;
  logic [XLEN-1:0] mul_product;

  logic            ex_mem_valid_q, ex_mem_valid_d;
  logic            ex_mem_regwrite_q, ex_mem_regwrite_d;
  logic            ex_mem_memread_q, ex_mem_memread_d;
  logic            ex_mem_memwrite_q, ex_mem_memwrite_d;
  logic [4:0]      ex_mem_rd_q, ex_mem_rd_d;
  logic [XLEN-1:0] ex_mem_result_q, ex_mem_result_d;
  logic [XLEN-1:0] ex_mem_store_q, ex_mem_store_d;

  // Code 11 is unused by the forwarding unit and falls back to the regfile.
  always_comb begin
    fwd_a = bus.id_ex_rs1_data;
    case (forwardA)
      FWD_EX:  fwd_a = ex_mem_result_q;
      FWD_MEM: fwd_a = mem_wb_fwd_data;
      default: fwd_a = bus.id_ex_rs1_data;
    endcase
    fwd_b = bus.id_ex_rs2_data;
    case (forwardB)
      FWD_EX:  fwd_b = ex_mem_result_q;
      FWD_MEM: fwd_b = mem_wb_fwd_data;
      default: fwd_b = bus.id_ex_rs2_data;
    endcase
  end

  assign op_b  = bus.id_ex_alu_src ? bus.id_ex_imm : fwd_b;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_result = '0;
    case (bus.id_ex_alu_op)
      ALU_ADD:   alu_result = fwd_a + op_b;
      ALU_SUB:   alu_result = fwd_a - op_b;
      ALU_AND:   alu_result = fwd_a & op_b;
      ALU_OR:    alu_result = fwd_a | op_b;
      ALU_XOR:   alu_result = fwd_a ^ op_b;
      ALU_SLL:   alu_result = fwd_a << shamt;
      ALU_SRL:   alu_result = fwd_a >> shamt;
      ALU_SRA:   alu_result = $signed(fwd_a) >>> shamt;
      ALU_SLT:   alu_result = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      ALU_SLTU:  alu_result = {{(XLEN-1){1'b0}}, (fwd_a < op_b)};
      ALU_PASSB: alu_result = op_b;
      default:   alu_result = '0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (bus.id_ex_br_type)
      BR_EQ:   br_cond = (fwd_a == fwd_b);
      BR_NE:   br_cond = (fwd_a != fwd_b);
      BR_LT:   br_cond = ($signed(fwd_a) <  $signed(fwd_b));
      BR_GE:   br_cond = ($signed(fwd_a) >= $signed(fwd_b));
      BR_LTU:  br_cond = (fwd_a <  fwd_b);
      BR_GEU:  br_cond = (fwd_a >= fwd_b);
      default: br_cond = 1'b0;
    endcase
  end

  assign mul_start = bus.id_ex_valid && (bus.id_ex_alu_op == ALU_MUL) && !mem_stall;

  iter_mul #(
    .XLEN       (XLEN),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_iter_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .hold    (mem_stall),
    .op_a    (fwd_a),
    .op_b    (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign ex_busy   = mul_busy;
  assign link_addr = bus.id_ex_pc + XLEN'(4);
  assign jalr_sum  = fwd_a + bus.id_ex_imm;

  assign branch_taken = bus.id_ex_valid && !mul_busy && !mem_stall &&
                        ((bus.id_ex_branch && br_cond) || bus.id_ex_jal || bus.id_ex_jalr);
  assign branch_target = bus.id_ex_jalr ? (jalr_sum & ~XLEN'(1))
                                        : (bus.id_ex_pc + bus.id_ex_imm);

  // Stall holds everything; the multiplier start cycle and BUSY cycles emit
  // bubbles; DONE loads the product with the still-held ID/EX controls.
  always_comb begin
    ex_mem_valid_d    = ex_mem_valid_q;
    ex_mem_regwrite_d = ex_mem_regwrite_q;
    ex_mem_memread_d  = ex_mem_memread_q;
    ex_mem_memwrite_d = ex_mem_memwrite_q;
    ex_mem_rd_d       = ex_mem_rd_q;
    ex_mem_result_d   = ex_mem_result_q;
    ex_mem_store_d    = ex_mem_store_q;
    if (!mem_stall) begin
      ex_mem_valid_d    = 1'b0;
      ex_mem_regwrite_d = 1'b0;
      ex_mem_memread_d  = 1'b0;
      ex_mem_memwrite_d = 1'b0;
      ex_mem_rd_d       = '0;
      ex_mem_result_d   = '0;
      ex_mem_store_d    = '0;
      if (!mul_busy && bus.id_ex_valid) begin
        ex_mem_valid_d    = 1'b1;
        ex_mem_regwrite_d = bus.id_ex_RegWrite;
        ex_mem_memread_d  = bus.id_ex_MemRead;
        ex_mem_memwrite_d = bus.id_ex_MemWrite;
        ex_mem_rd_d       = bus.id_ex_rd;
        ex_mem_store_d    = fwd_b;
        if (mul_done) begin
          ex_mem_result_d = mul_product;
        end else if (bus.id_ex_jal || bus.id_ex_jalr) begin
          ex_mem_result_d = link_addr;
        end else begin
          ex_mem_result_d = alu_result;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem_valid_q    <= 1'b0;
      ex_mem_regwrite_q <= 1'b0;
      ex_mem_memread_q  <= 1'b0;
      ex_mem_memwrite_q <= 1'b0;
      ex_mem_rd_q       <= '0;
      ex_mem_result_q   <= '0;
      ex_mem_store_q    <= '0;
    end else begin
      ex_mem_valid_q    <= ex_mem_valid_d;
      ex_mem_regwrite_q <= ex_mem_regwrite_d;
      ex_mem_memread_q  <= ex_mem_memread_d;
      ex_mem_memwrite_q <= ex_mem_memwrite_d;
      ex_mem_rd_q       <= ex_mem_rd_d;
      ex_mem_result_q   <= ex_mem_result_d;
      ex_mem_store_q    <= ex_mem_store_d;
    end
  end

  assign bus.ex_mem_valid      = ex_mem_valid_q;
  assign bus.ex_mem_RegWrite   = ex_mem_regwrite_q;
  assign bus.ex_mem_MemRead    = ex_mem_memread_q;
  assign bus.ex_mem_MemWrite   = ex_mem_memwrite_q;
  assign bus.ex_mem_rd         = ex_mem_rd_q;
  assign bus.ex_mem_alu_result = ex_mem_result_q;
  assign bus.ex_mem_store_data = ex_mem_store_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard-driven bench for the execute stage. Each scenario
// task drives ID/EX fields, pushes the expected EX/MEM contents, and pops and
// compares them once the loading edge has passed.
module tb_ex_stage;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  forwardA, forwardB;
  logic [31:0] mem_wb_fwd_data;
  logic        mem_stall;
  logic        ex_busy, branch_taken;
  logic [31:0] branch_target;

  always #5 clk = ~clk;

  ex_stage_if #(.XLEN(32)) bus ();

  ex_stage #(.XLEN(32), .MUL_CYCLES(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .forwardA        (forwardA),
    .forwardB        (forwardB),
    .mem_wb_fwd_data (mem_wb_fwd_data),
    .mem_stall       (mem_stall),
    .ex_busy         (ex_busy),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] result;
    logic [31:0] store;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_ex_valid    = 1'b0;
    bus.id_ex_pc       = '0;
    bus.id_ex_rs1_data = '0;
    bus.id_ex_rs2_data = '0;
    bus.id_ex_imm      = '0;
    bus.id_ex_rd       = '0;
    bus.id_ex_alu_op   = ALU_ADD;
    bus.id_ex_alu_src  = 1'b0;
    bus.id_ex_RegWrite = 1'b0;
    bus.id_ex_MemRead  = 1'b0;
    bus.id_ex_MemWrite = 1'b0;
    bus.id_ex_branch   = 1'b0;
    bus.id_ex_br_type  = 3'b000;
    bus.id_ex_jal      = 1'b0;
    bus.id_ex_jalr     = 1'b0;
    forwardA           = FWD_RF;
    forwardB           = FWD_RF;
    mem_stall          = 1'b0;
  endtask

  task automatic drive_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic src, input logic [4:0] rd,
                           input logic [1:0] fa, input logic [1:0] fb);
    clear_inputs();
    bus.id_ex_valid    = 1'b1;
    bus.id_ex_RegWrite = 1'b1;
    bus.id_ex_alu_op   = op;
    bus.id_ex_rs1_data = a;
    bus.id_ex_rs2_data = b;
    bus.id_ex_imm      = imm;
    bus.id_ex_alu_src  = src;
    bus.id_ex_rd       = rd;
    forwardA           = fa;
    forwardB           = fb;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    mem_wb_fwd_data = '0;
    #2;
    checks++;
    if ({bus.ex_mem_valid, bus.ex_mem_RegWrite, bus.ex_mem_MemRead, bus.ex_mem_MemWrite,
         bus.ex_mem_rd, bus.ex_mem_alu_result, bus.ex_mem_store_data} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_ex_mem: got v=%b rd=%0d res=%h st=%h, expected all zero",
               bus.ex_mem_valid, bus.ex_mem_rd, bus.ex_mem_alu_result, bus.ex_mem_store_data);
    end
    checks++;
    if ({ex_busy, branch_taken} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_busy_taken: got %b%b expected 00", ex_busy, branch_taken);
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_fwd_ex();
    exp_t e;
    drive_alu(ALU_ADD, 32'h8, 32'h8, 32'h0, 1'b0, 5'd1, FWD_RF, FWD_RF);
    sb.push_back('{rd: 5'd1, rw: 1'b1, result: 32'h10, store: 32'h8});
    tick();
    e = sb.pop_front();
    checks++;
    if ({bus.ex_mem_valid, bus.ex_mem_rd, bus.ex_mem_RegWrite, bus.ex_mem_alu_result, bus.ex_mem_store_data}
        !== {1'b1, e.rd, e.rw, e.result, e.store}) begin
      errors++;
      $display("[TB] FAIL fwd_ex_prev: got rd=%0d res=%h st=%h expected rd=%0d res=%h st=%h",
               bus.ex_mem_rd, bus.ex_mem_alu_result, bus.ex_mem_store_data, e.rd, e.result, e.store);
    end
    drive_alu(ALU_ADD, 32'h0, 32'h0, 32'h5, 1'b1, 5'd2, FWD_EX, FWD_RF);
    sb.push_back('{rd: 5'd2, rw: 1'b1, result: 32'h15, store: 32'h0});
    tick();
    e = sb.pop_front();
    checks++;
    if ({bus.ex_mem_valid, bus.ex_mem_rd, bus.ex_mem_RegWrite, bus.ex_mem_alu_result, bus.ex_mem_store_data}
        !== {1'b1, e.rd, e.rw, e.result, e.store}) begin
      errors++;
      $display("[TB] FAIL fwd_ex_addi: got rd=%0d res=%h st=%h expected rd=%0d res=%h st=%h",
               bus.ex_mem_rd, bus.ex_mem_alu_result, bus.ex_mem_store_data, e.rd, e.result, e.store);
    end
  endtask

  task automatic test_fwd_mem();
    exp_t e;
    mem_wb_fwd_data = 32'h7;
    drive_alu(ALU_SUB, 32'h9, 32'hDEAD, 32'h0, 1'b0, 5'd3, FWD_RF, FWD_MEM);
    sb.push_back('{rd: 5'd3, rw: 1'b1, result: 32'h2, store: 32'h7});
    tick();
    drive_alu(ALU_SUB, 32'h9, 32'h1, 32'h0, 1'b0, 5'd4, FWD_RF, FWD_RF);
    sb.push_back('{rd: 5'd4, rw: 1'b1, result: 32'h8, store: 32'h1});
    e = sb.pop_front();
    checks++;
    if ({bus.ex_mem_valid, bus.ex_mem_rd, bus.ex_mem_RegWrite, bus.ex_mem_alu_result, bus.ex_mem_store_data}
        !== {1'b1, e.rd, e.rw, e.result, e.store}) begin
      errors++;
      $display("[TB] FAIL fwd_mem_sub: got rd=%0d res=%h st=%h expected rd=%0d res=%h st=%h",
               bus.ex_mem_rd, bus.ex_mem_alu_result, bus.ex_mem_store_data, e.rd, e.result, e.store);
    end
    tick();
    e = sb.pop_front();
    checks++;
    if ({bus.ex_mem_valid, bus.ex_mem_rd, bus.ex_mem_RegWrite, bus.ex_mem_alu_result, bus.ex_mem_store_data}
        !== {1'b1, e.rd, e.rw, e.result, e.store}) begin
      errors++;
      $display("[TB] FAIL fwd_rf_sub: got rd=%0d res=%h st=%h expected rd=%0d res=%h st=%h",
               bus.ex_mem_rd, bus.ex_mem_alu_result, bus.ex_mem_store_data, e.rd, e.result, e.store);
    end
  endtask

  // Back-to-back ALU ops on A=0x800000F0, B=4; forwardA=11 must act as regfile.
  task automatic test_alu_ops();
    exp_t e;
    logic [3:0]  ops  [12] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
                               ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASSB, ALU_SLL};
    logic [31:0] exps [12] = '{32'h800000F4, 32'h800000EC, 32'h00000000, 32'h800000F4,
                               32'h800000F4, 32'h00000F00, 32'h0800000F, 32'hF800000F,
                               32'h00000001, 32'h00000000, 32'h00000004, 32'h00000F00};
    for (int i = 0; i < 12; i++) begin
      if (i == 11) begin
        drive_alu(ops[i], 32'h800000F0, 32'h4, 32'h24, 1'b1, 5'd9, 2'b11, FWD_RF);
      end else begin
        drive_alu(ops[i], 32'h800000F0, 32'h4, 32'h0, 1'b0, 5'(i + 10), 2'b11, FWD_RF);
      end
      sb.push_back('{rd: (i == 11) ? 5'd9 : 5'(i + 10), rw: 1'b1, result: exps[i], store: 32'h4});
      tick();
      e = sb.pop_front();
      checks++;
      if ({bus.ex_mem_valid, bus.ex_mem_rd, bus.ex_mem_RegWrite, bus.ex_mem_alu_result, bus.ex_mem_store_data}
          !== {1'b1, e.rd, e.rw, e.result, e.store}) begin
        errors++;
        $display("[TB] FAIL alu_op%0d: got rd=%0d res=%h st=%h expected rd=%0d res=%h st=%h",
                 ops[i], bus.ex_mem_rd, bus.ex_mem_alu_result, bus.ex_mem_store_data,
                 e.rd, e.result, e.store);
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0] types [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    logic       taken [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      clear_inputs();
      bus.id_ex_valid    = 1'b1;
      bus.id_ex_branch   = 1'b1;
      bus.id_ex_br_type  = types[i];
      bus.id_ex_rs1_data = 32'hFFFFFFFE;
      bus.id_ex_rs2_data = 32'h1;
      bus.id_ex_pc       = 32'h100;
      bus.id_ex_imm      = 32'h20;
      #1;
      checks++;
      if (branch_taken !== taken[i] || (taken[i] && branch_target !== 32'h120)) begin
        errors++;
        $display("[TB] FAIL branch_f3_%b: got taken=%b tgt=%h expected taken=%b tgt=00000120",
                 types[i], branch_taken, branch_target, taken[i]);
      end
      tick();
    end
    bus.id_ex_valid   = 1'b0;
    bus.id_ex_br_type = BR_LT;
    #1;
    checks++;
    if (branch_taken !== 1'b0) begin
      errors++;
      $display("[TB] FAIL branch_bubble: got taken=%b expected 0", branch_taken);
    end
    tick();
  endtask

  task automatic test_jump();
    exp_t e;
    drive_alu(ALU_ADD, 32'h0, 32'h0, 32'h40, 1'b1, 5'd1, FWD_RF, FWD_RF);
    bus.id_ex_jal = 1'b1;
    bus.id_ex_pc  = 32'h200;
    sb.push_back('{rd: 5'd1, rw: 1'b1, result: 32'h204, store: 32'h0});
    #1;
    checks++;
    if ({branch_taken, branch_target} !== {1'b1, 32'h240}) begin
      errors++;
      $display("[TB] FAIL jal_target: got taken=%b tgt=%h expected taken=1 tgt=00000240",
               branch_taken, branch_target);
    end
    tick();
    e = sb.pop_front();
    checks++;
    if ({bus.ex_mem_valid, bus.ex_mem_rd, bus.ex_mem_RegWrite, bus.ex_mem_alu_result}
        !== {1'b1, e.rd, e.rw, e.result}) begin
      errors++;
      $display("[TB] FAIL jal_link: got rd=%0d res=%h expected rd=%0d res=%h",
               bus.ex_mem_rd, bus.ex_mem_alu_result, e.rd, e.result);
    end
    drive_alu(ALU_ADD, 32'h1001, 32'h0, 32'h10, 1'b1, 5'd2, FWD_RF, FWD_RF);
    bus.id_ex_jalr = 1'b1;
    bus.id_ex_pc   = 32'h300;
    sb.push_back('{rd: 5'd2, rw: 1'b1, result: 32'h304, store: 32'h0});
    #1;
    checks++;
    if ({branch_taken, branch_target} !== {1'b1, 32'h1010}) begin
      errors++;
      $display("[TB] FAIL jalr_target: got taken=%b tgt=%h expected taken=1 tgt=00001010",
               branch_taken, branch_target);
    end
    tick();
    e = sb.pop_front();
    checks++;
    if ({bus.ex_mem_valid, bus.ex_mem_rd, bus.ex_mem_RegWrite, bus.ex_mem_alu_result}
        !== {1'b1, e.rd, e.rw, e.result}) begin
      errors++;
      $display("[TB] FAIL jalr_link: got rd=%0d res=%h expected rd=%0d res=%h",
               bus.ex_mem_rd, bus.ex_mem_alu_result, e.rd, e.result);
    end
  endtask

  task automatic test_mul();
    exp_t e;
    int   n = 0;
    logic saw_valid = 1'b0;
    drive_alu(ALU_MUL, 32'hFFFFFFFF, 32'h3, 32'h0, 1'b0, 5'd5, FWD_RF, FWD_RF);
    sb.push_back('{rd: 5'd5, rw: 1'b1, result: 32'hFFFFFFFD, store: 32'h0});
    #1;
    checks++;
    if ({ex_busy, branch_taken} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL mul_start: got busy=%b taken=%b expected busy=1 taken=0", ex_busy, branch_taken);
    end
    while (ex_busy === 1'b1 && n < 100) begin
      tick();
      n++;
      if (n == 1) begin
        bus.id_ex_rs1_data = 32'h0;
        bus.id_ex_rs2_data = 32'h0;
      end
      if (bus.ex_mem_valid !== 1'b0) saw_valid = 1'b1;
    end
    checks++;
    if (n != 33) begin
      errors++;
      $display("[TB] FAIL mul_busy_cycles: got %0d expected 33", n);
    end
    checks++;
    if (saw_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mul_bubbles: got valid output during busy, expected none");
    end
    mem_stall = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.ex_mem_valid, ex_busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL mul_done_stall: got valid=%b busy=%b expected 00", bus.ex_mem_valid, ex_busy);
    end
    mem_stall = 1'b0;
    tick();
    clear_inputs();
    e = sb.pop_front();
    checks++;
    if ({bus.ex_mem_valid, bus.ex_mem_rd, bus.ex_mem_RegWrite, bus.ex_mem_alu_result}
        !== {1'b1, e.rd, e.rw, e.result}) begin
      errors++;
      $display("[TB] FAIL mul_result: got v=%b rd=%0d rw=%b res=%h expected v=1 rd=%0d rw=%b res=%h",
               bus.ex_mem_valid, bus.ex_mem_rd, bus.ex_mem_RegWrite, bus.ex_mem_alu_result,
               e.rd, e.rw, e.result);
    end
    tick();
  endtask

  task automatic test_stall();
    exp_t e;
    drive_alu(ALU_ADD, 32'h1, 32'h1, 32'h0, 1'b0, 5'd3, FWD_RF, FWD_RF);
    sb.push_back('{rd: 5'd3, rw: 1'b1, result: 32'h2, store: 32'h1});
    tick();
    e = sb.pop_front();
    checks++;
    if ({bus.ex_mem_valid, bus.ex_mem_rd, bus.ex_mem_alu_result} !== {1'b1, e.rd, e.result}) begin
      errors++;
      $display("[TB] FAIL stall_pre: got rd=%0d res=%h expected rd=%0d res=%h",
               bus.ex_mem_rd, bus.ex_mem_alu_result, e.rd, e.result);
    end
    drive_alu(ALU_ADD, 32'h30, 32'h4, 32'h0, 1'b0, 5'd4, FWD_RF, FWD_RF);
    sb.push_back('{rd: 5'd4, rw: 1'b1, result: 32'h34, store: 32'h4});
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.ex_mem_valid, bus.ex_mem_rd, bus.ex_mem_alu_result} !== {1'b1, 5'd3, 32'h2}) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: got rd=%0d res=%h expected rd=3 res=00000002",
                 i, bus.ex_mem_rd, bus.ex_mem_alu_result);
      end
    end
    mem_stall = 1'b0;
    tick();
    e = sb.pop_front();
    checks++;
    if ({bus.ex_mem_valid, bus.ex_mem_rd, bus.ex_mem_alu_result, bus.ex_mem_store_data}
        !== {1'b1, e.rd, e.result, e.store}) begin
      errors++;
      $display("[TB] FAIL stall_release: got rd=%0d res=%h st=%h expected rd=%0d res=%h st=%h",
               bus.ex_mem_rd, bus.ex_mem_alu_result, bus.ex_mem_store_data, e.rd, e.result, e.store);
    end
    drive_alu(ALU_ADD, 32'h0, 32'h0, 32'h8, 1'b1, 5'd1, FWD_RF, FWD_RF);
    bus.id_ex_jal = 1'b1;
    bus.id_ex_pc  = 32'h400;
    mem_stall     = 1'b1;
    #1;
    checks++;
    if (branch_taken !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_no_redirect: got taken=%b expected 0", branch_taken);
    end
    mem_stall = 1'b0;
    #1;
    checks++;
    if ({branch_taken, branch_target} !== {1'b1, 32'h408}) begin
      errors++;
      $display("[TB] FAIL stall_then_jal: got taken=%b tgt=%h expected taken=1 tgt=00000408",
               branch_taken, branch_target);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_mul();
    exp_t e;
    drive_alu(ALU_MUL, 32'h2, 32'h3, 32'h0, 1'b0, 5'd6, FWD_RF, FWD_RF);
    for (int i = 0; i < 11; i++) tick();
    checks++;
    if (ex_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_mul_running: got busy=%b expected 1", ex_busy);
    end
    clear_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ex_busy, bus.ex_mem_valid, bus.ex_mem_RegWrite, bus.ex_mem_rd, bus.ex_mem_alu_result} !== '0) begin
      errors++;
      $display("[TB] FAIL rst_mid_mul: got busy=%b v=%b rd=%0d res=%h expected all zero",
               ex_busy, bus.ex_mem_valid, bus.ex_mem_rd, bus.ex_mem_alu_result);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({ex_busy, bus.ex_mem_valid} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL rst_no_pulse%0d: got busy=%b valid=%b expected 00", i, ex_busy, bus.ex_mem_valid);
      end
    end
    drive_alu(ALU_ADD, 32'h2, 32'h3, 32'h0, 1'b0, 5'd7, FWD_RF, FWD_RF);
    sb.push_back('{rd: 5'd7, rw: 1'b1, result: 32'h5, store: 32'h3});
    tick();
    e = sb.pop_front();
    checks++;
    if ({bus.ex_mem_valid, bus.ex_mem_rd, bus.ex_mem_RegWrite, bus.ex_mem_alu_result, bus.ex_mem_store_data}
        !== {1'b1, e.rd, e.rw, e.result, e.store}) begin
      errors++;
      $display("[TB] FAIL rst_then_add: got rd=%0d res=%h st=%h expected rd=%0d res=%h st=%h",
               bus.ex_mem_rd, bus.ex_mem_alu_result, bus.ex_mem_store_data, e.rd, e.result, e.store);
    end
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_fwd_ex();
    test_fwd_mem();
    test_alu_ops();
    test_branch();
    test_jump();
    test_mul();
    test_stall();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
